// File: rtl/stage_sequencer.sv
// stage_sequencer: walks the network through stages 1..37 one at a time.
// For each stage it pulses calc_start, then waits for the engine's
// calc_done strobe. After the FC stage (37) it shows stage 38 (RESULT)
// for one cycle with net_done and returns to idle.
// Optional feature macro SEQ_TIMEOUT_EN: adds a wait counter that aborts
// the run with a sticky error flag once TIMEOUT_CYCLES wait cycles pass
// without calc_done. When the macro is undefined, error is tied low.
module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [5:0] stage,
    output logic [2:0] stage_type,
    output logic       calc_start,
    input  logic       calc_done,
    output logic       net_done,
    output logic       error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [5:0] STG_IDLE      = 6'd0;
    localparam logic [5:0] STG_GLOBAL_DW = 6'd1;
    localparam logic [5:0] STG_FC        = 6'd37;
    localparam logic [5:0] STG_RESULT    = 6'd38;

    state_t     state_q, state_d;
    logic [5:0] stage_q, stage_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             error_q, error_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Control registers: state, stage id, and (optionally) timeout bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stage_q    <= STG_IDLE;
`ifdef SEQ_TIMEOUT_EN
            error_q    <= 1'b0;
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
`ifdef SEQ_TIMEOUT_EN
            error_q    <= error_d;
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Next-state logic: start only accepted in idle, calc_done only in wait
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
`ifdef SEQ_TIMEOUT_EN
        error_d    = error_q;
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = STG_GLOBAL_DW;
`ifdef SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (calc_done) begin
                    if (stage_q == STG_FC) begin
                        state_d = S_FIN;
                        stage_d = STG_RESULT;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 6'd1;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    stage_d = STG_IDLE;
                    error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
                stage_d = STG_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                stage_d = STG_IDLE;
            end
        endcase
    end

    // Outputs: state-decoded strobes and the combinational stage-type decode
    always_comb begin
        busy       = (state_q != S_IDLE);
        calc_start = (state_q == S_ISSUE);
        net_done   = (state_q == S_FIN);
        stage      = stage_q;
        case (stage_q)
            6'd1, 6'd8, 6'd20, 6'd26, 6'd32:
                stage_type = 3'd1;
            6'd4, 6'd15:
                stage_type = 3'd2;
            6'd3, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd13, 6'd14,
            6'd16, 6'd17, 6'd18, 6'd19, 6'd21, 6'd22, 6'd24, 6'd25,
            6'd27, 6'd28, 6'd30, 6'd31, 6'd33, 6'd34:
                stage_type = 3'd3;
            6'd2, 6'd12:
                stage_type = 3'd4;
            6'd36:
                stage_type = 3'd5;
            6'd11, 6'd23, 6'd29, 6'd35:
                stage_type = 3'd6;
            6'd37:
                stage_type = 3'd7;
            default:
                stage_type = 3'd0;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
